vga_capture: RTL

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_edge_det.sv | 26 ++
 rtl/vga_capture.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: types and default 640x480@60 timing shared by the VGA
// capture and output blocks.
package vga_pkg;

    typedef logic [2:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        V_BACK,
        H_SYNC,
        H_BACK,
        ACTIVE
    } cap_state_t;

    // Default 640x480 timing, in pixels (horizontal) and lines (vertical)
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC_W = 96;
    localparam int H_BACK_W = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC_W = 2;
    localparam int V_BACK_W = 33;

endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det: registers a sync input once and flags its falling edge.
// Ports: clk, srst (sync, active-high), d (raw input), q (registered
// copy), fall (high for the cycle in which q has just dropped).
module vga_edge_det (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q,
    output logic fall
);

    logic q_d;

    always_ff @(posedge clk) begin
        if (srst) begin
            q   <= 1'b0;
            q_d <= 1'b0;
        end else begin
            q   <= d;
            q_d <= q;
        end
    end

    assign fall = q_d & ~q;

endmodule

// File: rtl/vga_capture.sv
// vga_capture: captures active video from a VGA-style stream and
// emits framebuffer writes two cycles after the pixel is on the pins.
// Ports: clk, srst; width/height/h_back/v_back timing config;
// hsync_in/vsync_in/rgb_in video; enable arms capture;
// X/Y/pixel/wr_en write port; frame_done, busy, err status.
module vga_capture
    import vga_pkg::*;
#(
    parameter int MAX_W = H_ACTIVE,
    parameter int MAX_H = V_ACTIVE
) (
    input  logic       clk,
    input  logic       srst,
    input  logic [9:0] width,
    input  logic [9:0] height,
    input  logic [7:0] h_back,
    input  logic [7:0] v_back,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  pixel_t     rgb_in,
    input  logic       enable,
    output logic [9:0] X,
    output logic [9:0] Y,
    output pixel_t     pixel,
    output logic       wr_en,
    output logic       frame_done,
    output logic       busy,
    output logic       err
);

    localparam logic [9:0] W_LIM =
        (MAX_W > 1023) ? 10'd1023 : 10'(MAX_W);
    localparam logic [9:0] H_LIM =
        (MAX_H > 1023) ? 10'd1023 : 10'(MAX_H);

    logic       hs_q, hs_fall;
    logic       vs_q, vs_fall;
    pixel_t     rgb_q;
    cap_state_t state;
    cap_state_t fs_state;
    logic [9:0] pcnt, lcnt, wid_l, hgt_l;
    logic [7:0] pb_cnt, vb_cnt, hb_l, vb_l;
    logic       fd_pend;
    logic       w_ok, f_ok, fs_go, line_go;
    logic       wr_now, eol, eof;
    logic [9:0] x_now, wid_now;

    vga_edge_det u_hs (
        .clk  (clk),
        .srst (srst),
        .d    (hsync_in),
        .q    (hs_q),
        .fall (hs_fall)
    );

    vga_edge_det u_vs (
        .clk  (clk),
        .srst (srst),
        .d    (vsync_in),
        .q    (vs_q),
        .fall (vs_fall)
    );

    assign w_ok = (width != 10'd0) && (width <= W_LIM);
    assign f_ok = w_ok && (height != 10'd0) && (height <= H_LIM);
    assign fs_state = (v_back == 8'd0) ? H_SYNC : V_BACK;

    // Frame start: armed start from IDLE, or a premature vsync fall
    // while waiting for a line, which restarts the frame.
    assign fs_go = vs_fall &&
        ((state == IDLE && enable) ||
         (state inside {V_BACK, H_SYNC, H_BACK}));

    // Line start: the hsync fall that opens an active line. The pixel
    // registered in this cycle is the first one after the fall.
    assign line_go = hs_fall && !vs_fall &&
        ((state == H_SYNC) ||
         (state == V_BACK && (vb_cnt + 8'd1) == vb_l));

    // With no horizontal porch the fall cycle already carries X = 0.
    assign wr_now = (state == ACTIVE && !hs_q && !vs_q) ||
                    (line_go && w_ok && h_back == 8'd0);
    assign x_now   = (state == ACTIVE) ? pcnt : 10'd0;
    assign wid_now = (state == ACTIVE) ? wid_l : width;
    assign eol = wr_now && (x_now == wid_now - 10'd1);
    assign eof = eol && (lcnt == hgt_l - 10'd1);

    always_ff @(posedge clk) begin
        if (srst) begin
            rgb_q      <= '0;
            state      <= IDLE;
            pcnt       <= '0;
            lcnt       <= '0;
            wid_l      <= '0;
            hgt_l      <= '0;
            pb_cnt     <= '0;
            vb_cnt     <= '0;
            hb_l       <= '0;
            vb_l       <= '0;
            fd_pend    <= 1'b0;
            X          <= '0;
            Y          <= '0;
            pixel      <= '0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            rgb_q      <= rgb_in;
            wr_en      <= wr_now;
            pixel      <= wr_now ? rgb_q : '0;
            fd_pend    <= eof;
            frame_done <= fd_pend;
            if (wr_now) begin
                X <= x_now;
                Y <= lcnt;
            end

            if (fs_go) begin
                if (state != IDLE)
                    err <= 1'b1;
                if (f_ok) begin
                    hgt_l  <= height;
                    vb_l   <= v_back;
                    lcnt   <= '0;
                    vb_cnt <= '0;
                    state  <= fs_state;
                    busy   <= 1'b1;
                end else begin
                    err    <= 1'b1;
                    state  <= IDLE;
                    busy   <= 1'b0;
                end
            end else begin
                unique case (state)
                    IDLE: ;
                    V_BACK, H_SYNC: begin
                        if (line_go) begin
                            if (!w_ok) begin
                                err   <= 1'b1;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                wid_l <= width;
                                hb_l  <= h_back;
                                pcnt  <= '0;
                                if (h_back == 8'd0) begin
                                    if (eof) begin
                                        state <= IDLE;
                                        busy  <= 1'b0;
                                    end else if (eol) begin
                                        state <= H_SYNC;
                                        lcnt  <= lcnt + 10'd1;
                                    end else begin
                                        state <= ACTIVE;
                                        pcnt  <= 10'd1;
                                    end
                                end else if (h_back == 8'd1) begin
                                    state <= ACTIVE;
                                end else begin
                                    // fall cycle was porch pixel 0
                                    state  <= H_BACK;
                                    pb_cnt <= 8'd1;
                                end
                            end
                        end else if (hs_fall) begin
                            vb_cnt <= vb_cnt + 8'd1;
                        end
                    end
                    H_BACK: begin
                        if (pb_cnt == hb_l - 8'd1) begin
                            state <= ACTIVE;
                            pcnt  <= '0;
                        end else begin
                            pb_cnt <= pb_cnt + 8'd1;
                        end
                    end
                    ACTIVE: begin
                        if (hs_q || vs_q) begin
                            err   <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (eof) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (eol) begin
                            state <= H_SYNC;
                            lcnt  <= lcnt + 10'd1;
                        end else begin
                            pcnt <= pcnt + 10'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
